// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack boot sequencer.
package hack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CSUM,
    ST_RUN,
    ST_ERROR
  } hack_boot_state_t;

  localparam logic [7:0] HACK_SYNC_BYTE = 8'hA5;
  localparam int         HACK_ROM_DEPTH = 1001;

endpackage

// File: rtl/hack_boot_ctrl_if.sv
// UART byte stream, shell halt, ROM write bus and status of the boot sequencer.
// Handshake: i_rx_byte is valid only in a cycle with i_rx_dv high; there is no backpressure,
// so every strobed byte is consumed (or deliberately dropped) in that same cycle.
interface hack_boot_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        i_rx_byte;
  logic              i_rx_dv;
  logic              i_halt;
  logic              o_rom_cs;
  logic              o_rom_write;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [15:0]       o_rom_data;
  logic              o_cpu_reset;
  logic              o_mode;
  logic              o_error;
  logic [ADDR_W-1:0] o_words_loaded;

  modport master (
    input  i_rx_byte, i_rx_dv, i_halt,
    output o_rom_cs, o_rom_write, o_rom_addr, o_rom_data,
    output o_cpu_reset, o_mode, o_error, o_words_loaded
  );

  modport slave (
    output i_rx_byte, i_rx_dv, i_halt,
    input  o_rom_cs, o_rom_write, o_rom_addr, o_rom_data,
    input  o_cpu_reset, o_mode, o_error, o_words_loaded
  );
endinterface

// File: rtl/hack_gap_timer.sv
// Counts idle cycles between received bytes; expired stays high once the limit is reached.
module hack_gap_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (reset || clear || !enable) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired = enable && (cnt_q == LAST);
endmodule

// File: rtl/hack_boot_ctrl.sv
// Boot sequencer: receives a framed, XOR-checked program image over UART, writes it to ROM,
// then releases the CPU; a shell halt returns it to boot mode.
module hack_boot_ctrl
  import hack_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int ROM_DEPTH      = HACK_ROM_DEPTH,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    CLK,
  input  logic                    i_reset,
  hack_boot_ctrl_if.master        bus,
  output hack_boot_state_t        o_dbg_state
);
  hack_boot_state_t  state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        acc_q, acc_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              wr_q, wr_d;
  logic              cpu_reset_q, mode_q, error_q;
  logic              gap_en, gap_clr, gap_expired;

  wire       dv   = bus.i_rx_dv;
  wire [7:0] rx_b = bus.i_rx_byte;

  assign gap_en  = (state_q inside {ST_CNT_HI, ST_CNT_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM});
  assign gap_clr = dv || (state_d != state_q);

  hack_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
    .CLK     (CLK),
    .reset   (i_reset),
    .clear   (gap_clr),
    .enable  (gap_en),
    .expired (gap_expired)
  );

  always_ff @(posedge CLK) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      hi_q        <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      mode_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      cpu_reset_q <= (state_d != ST_RUN);
      mode_q      <= (state_d == ST_RUN);
      error_q     <= (state_d == ST_ERROR);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (dv && rx_b == HACK_SYNC_BYTE) state_d = ST_CNT_HI;
      end
      ST_CNT_HI: begin
        if (dv) begin
          count_d[15:8] = rx_b;
          state_d       = ST_CNT_LO;
        end else if (gap_expired) state_d = ST_ERROR;
      end
      ST_CNT_LO: begin
        if (dv) begin
          count_d = {count_q[15:8], rx_b};
          idx_d   = '0;
          acc_d   = '0;
          if (count_d == 16'd0)                state_d = ST_CSUM;
          else if (int'(count_d) > ROM_DEPTH)  state_d = ST_ERROR;
          else                                 state_d = ST_DATA_HI;
        end else if (gap_expired) state_d = ST_ERROR;
      end
      ST_DATA_HI: begin
        if (dv) begin
          hi_d    = rx_b;
          acc_d   = acc_q ^ rx_b;
          state_d = ST_DATA_LO;
        end else if (gap_expired) state_d = ST_ERROR;
      end
      ST_DATA_LO: begin
        // The write strobe is registered, so it appears the cycle after the low byte.
        if (dv) begin
          wr_d    = 1'b1;
          addr_d  = idx_q;
          data_d  = {hi_q, rx_b};
          idx_d   = idx_q + ADDR_W'(1);
          acc_d   = acc_q ^ rx_b;
          state_d = (int'(idx_d) == int'(count_q)) ? ST_CSUM : ST_DATA_HI;
        end else if (gap_expired) state_d = ST_ERROR;
      end
      ST_CSUM: begin
        if (dv) state_d = (rx_b == acc_q) ? ST_RUN : ST_ERROR;
        else if (gap_expired) state_d = ST_ERROR;
      end
      ST_RUN: begin
        // Bytes are ignored here, including one that arrives together with the halt.
        if (bus.i_halt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_rom_cs       = cpu_reset_q;
  assign bus.o_cpu_reset    = cpu_reset_q;
  assign bus.o_mode         = mode_q;
  assign bus.o_error        = error_q;
  assign bus.o_rom_write    = wr_q;
  assign bus.o_rom_addr     = addr_q;
  assign bus.o_rom_data     = data_q;
  assign bus.o_words_loaded = idx_q;
  assign o_dbg_state        = state_q;
endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Directed bench for hack_boot_ctrl: a per-cycle vector table plus timeout sequences.
module tb_hack_boot_ctrl;
  import hack_pkg::*;

  localparam int W = 56;

  logic CLK = 1'b0;
  logic i_reset;
  hack_boot_state_t dbg_state;

  hack_boot_ctrl_if #(.ADDR_W(16)) bus ();

  hack_boot_ctrl #(.ADDR_W(16), .ROM_DEPTH(1001), .TIMEOUT_CYCLES(16)) dut (
    .CLK         (CLK),
    .i_reset     (i_reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200000");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic             rst;
    logic             dv;
    logic [7:0]       b;
    logic             halt;
    hack_boot_state_t st;
    logic             wr;
    logic [15:0]      a;
    logic [15:0]      d;
    logic [15:0]      w;
    logic             err;
  } vec_t;

  vec_t           vecs[$];
  logic [W-1:0]   exp_q[$];
  int             n_cmp = 0;
  int             n_err = 0;

  function automatic logic [W-1:0] pack(hack_boot_state_t st, logic wr, logic [15:0] a,
                                        logic [15:0] d, logic [15:0] w, logic err);
    logic in_run;
    in_run = (st == ST_RUN);
    return {st, wr, a, d, w, !in_run, !in_run, in_run, err};
  endfunction

  // driver
  task automatic step(input logic rst, input logic dv, input logic [7:0] b, input logic halt);
    @(negedge CLK);
    i_reset       = rst;
    bus.i_rx_dv   = dv;
    bus.i_rx_byte = b;
    bus.i_halt    = halt;
    @(posedge CLK);
    #1;
  endtask

  // scoreboard
  task automatic check(input string name);
    logic [W-1:0] exp, act;
    exp = exp_q.pop_front();
    act = {dbg_state, bus.o_rom_write, bus.o_rom_addr, bus.o_rom_data, bus.o_words_loaded,
           bus.o_cpu_reset, bus.o_rom_cs, bus.o_mode, bus.o_error};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input hack_boot_state_t st, input logic wr,
                            input logic [15:0] a, input logic [15:0] d, input logic [15:0] w,
                            input logic err);
    exp_q.push_back(pack(st, wr, a, d, w, err));
    check(name);
  endtask

  task automatic add(input logic rst, input logic dv, input logic [7:0] b, input logic halt,
                     input hack_boot_state_t st, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] w, input logic err);
    vec_t v;
    v = '{rst, dv, b, halt, st, wr, a, d, w, err};
    vecs.push_back(v);
  endtask

  initial begin
    i_reset = 1'b1; bus.i_rx_dv = 1'b0; bus.i_rx_byte = 8'h00; bus.i_halt = 1'b0;

    // good frame, then halt
    add(0,1,8'hA5,0, ST_CNT_HI, 0,16'h0000,16'h0000,16'd0,0);
    add(0,1,8'h00,0, ST_CNT_LO, 0,16'h0000,16'h0000,16'd0,0);
    add(0,1,8'h02,0, ST_DATA_HI,0,16'h0000,16'h0000,16'd0,0);
    add(0,1,8'h12,0, ST_DATA_LO,0,16'h0000,16'h0000,16'd0,0);
    add(0,1,8'h34,0, ST_DATA_HI,1,16'h0000,16'h1234,16'd1,0);
    add(0,0,8'h00,0, ST_DATA_HI,0,16'h0000,16'h1234,16'd1,0);
    add(0,1,8'hAB,0, ST_DATA_LO,0,16'h0000,16'h1234,16'd1,0);
    add(0,1,8'hCD,0, ST_CSUM,   1,16'h0001,16'hABCD,16'd2,0);
    add(0,1,8'h40,0, ST_RUN,    0,16'h0001,16'hABCD,16'd2,0);
    add(0,0,8'h00,0, ST_RUN,    0,16'h0001,16'hABCD,16'd2,0);
    add(0,0,8'h00,1, ST_IDLE,   0,16'h0001,16'hABCD,16'd2,0);
    // bad checksum, garbage in ERROR, then a valid one-word frame
    add(0,1,8'hA5,0, ST_CNT_HI, 0,16'h0001,16'hABCD,16'd2,0);
    add(0,1,8'h00,0, ST_CNT_LO, 0,16'h0001,16'hABCD,16'd2,0);
    add(0,1,8'h02,0, ST_DATA_HI,0,16'h0001,16'hABCD,16'd0,0);
    add(0,1,8'h12,0, ST_DATA_LO,0,16'h0001,16'hABCD,16'd0,0);
    add(0,1,8'h34,0, ST_DATA_HI,1,16'h0000,16'h1234,16'd1,0);
    add(0,1,8'hAB,0, ST_DATA_LO,0,16'h0000,16'h1234,16'd1,0);
    add(0,1,8'hCD,0, ST_CSUM,   1,16'h0001,16'hABCD,16'd2,0);
    add(0,1,8'h41,0, ST_ERROR,  0,16'h0001,16'hABCD,16'd2,1);
    add(0,1,8'h11,0, ST_ERROR,  0,16'h0001,16'hABCD,16'd2,1);
    add(0,1,8'hA5,0, ST_CNT_HI, 0,16'h0001,16'hABCD,16'd2,0);
    add(0,1,8'h00,0, ST_CNT_LO, 0,16'h0001,16'hABCD,16'd2,0);
    add(0,1,8'h01,0, ST_DATA_HI,0,16'h0001,16'hABCD,16'd0,0);
    add(0,1,8'hBE,0, ST_DATA_LO,0,16'h0001,16'hABCD,16'd0,0);
    add(0,1,8'hEF,0, ST_CSUM,   1,16'h0000,16'hBEEF,16'd1,0);
    add(0,1,8'h51,0, ST_RUN,    0,16'h0000,16'hBEEF,16'd1,0);
    // halt and sync together: halt wins, the A5 is not a sync
    add(0,1,8'hA5,1, ST_IDLE,   0,16'h0000,16'hBEEF,16'd1,0);
    add(0,0,8'h00,0, ST_IDLE,   0,16'h0000,16'hBEEF,16'd1,0);
    add(0,1,8'hA5,0, ST_CNT_HI, 0,16'h0000,16'hBEEF,16'd1,0);
    add(0,1,8'h00,0, ST_CNT_LO, 0,16'h0000,16'hBEEF,16'd1,0);
    add(0,1,8'h01,0, ST_DATA_HI,0,16'h0000,16'hBEEF,16'd0,0);
    add(0,1,8'h00,0, ST_DATA_LO,0,16'h0000,16'hBEEF,16'd0,0);
    add(0,1,8'h07,0, ST_CSUM,   1,16'h0000,16'h0007,16'd1,0);
    add(0,1,8'h07,0, ST_RUN,    0,16'h0000,16'h0007,16'd1,0);
    add(0,0,8'h00,1, ST_IDLE,   0,16'h0000,16'h0007,16'd1,0);
    // garbage in IDLE, count 1002 rejected, count 1001 accepted
    add(0,1,8'h11,0, ST_IDLE,   0,16'h0000,16'h0007,16'd1,0);
    add(0,1,8'h22,0, ST_IDLE,   0,16'h0000,16'h0007,16'd1,0);
    add(0,1,8'hA5,0, ST_CNT_HI, 0,16'h0000,16'h0007,16'd1,0);
    add(0,1,8'h03,0, ST_CNT_LO, 0,16'h0000,16'h0007,16'd1,0);
    add(0,1,8'hEA,0, ST_ERROR,  0,16'h0000,16'h0007,16'd0,1);
    add(0,0,8'h00,0, ST_ERROR,  0,16'h0000,16'h0007,16'd0,1);
    add(0,1,8'hA5,0, ST_CNT_HI, 0,16'h0000,16'h0007,16'd0,0);
    add(0,1,8'h03,0, ST_CNT_LO, 0,16'h0000,16'h0007,16'd0,0);
    add(0,1,8'hE9,0, ST_DATA_HI,0,16'h0000,16'h0007,16'd0,0);
    add(0,1,8'h12,0, ST_DATA_LO,0,16'h0000,16'h0007,16'd0,0);
    // reset together with the low byte: no strobe, everything cleared
    add(1,1,8'h34,0, ST_IDLE,   0,16'h0000,16'h0000,16'd0,0);
    add(0,0,8'h00,0, ST_IDLE,   0,16'h0000,16'h0000,16'd0,0);
    // zero-length image
    add(0,1,8'hA5,0, ST_CNT_HI, 0,16'h0000,16'h0000,16'd0,0);
    add(0,1,8'h00,0, ST_CNT_LO, 0,16'h0000,16'h0000,16'd0,0);
    add(0,1,8'h00,0, ST_CSUM,   0,16'h0000,16'h0000,16'd0,0);
    add(0,1,8'h00,0, ST_RUN,    0,16'h0000,16'h0000,16'd0,0);
    add(0,0,8'h00,1, ST_IDLE,   0,16'h0000,16'h0000,16'd0,0);

    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    expect_out("reset", ST_IDLE, 0, 16'h0000, 16'h0000, 16'd0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].dv, vecs[i].b, vecs[i].halt);
      expect_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].wr, vecs[i].a, vecs[i].d,
                 vecs[i].w, vecs[i].err);
    end

    // timeout: silence after the high data byte expires 16 cycles after it
    step(0, 1, 8'hA5, 0);
    step(0, 1, 8'h00, 0);
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h12, 0);
    expect_out("to_start", ST_DATA_LO, 0, 16'h0000, 16'h0000, 16'd0, 0);
    for (int k = 1; k <= 15; k++) begin
      step(0, 0, 8'h00, 0);
      expect_out($sformatf("to_wait%0d", k), ST_DATA_LO, 0, 16'h0000, 16'h0000, 16'd0, 0);
    end
    step(0, 0, 8'h00, 0);
    expect_out("to_expire", ST_ERROR, 0, 16'h0000, 16'h0000, 16'd0, 1);

    // a byte landing on the expiry cycle is still accepted
    step(0, 1, 8'hA5, 0);
    expect_out("to2_sync", ST_CNT_HI, 0, 16'h0000, 16'h0000, 16'd0, 0);
    for (int k = 1; k <= 15; k++) step(0, 0, 8'h00, 0);
    expect_out("to2_wait", ST_CNT_HI, 0, 16'h0000, 16'h0000, 16'd0, 0);
    step(0, 1, 8'h00, 0);
    expect_out("to2_accept", ST_CNT_LO, 0, 16'h0000, 16'h0000, 16'd0, 0);

    step(1, 0, 8'h00, 0);
    expect_out("final_reset", ST_IDLE, 0, 16'h0000, 16'h0000, 16'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hack_boot_ctrl.md
# hack_boot_ctrl

Boot sequencer for the Hack system. It owns the ROM write bus while the CPU is held in reset, and receives a program image as a byte stream from the UART receiver. It checks the image and writes it word-by-word into ROM, then releases the CPU into run mode. It also returns the system to boot mode on a halt request from the shell.

## Interface
Parameters:
- ADDR_W, 16, ROM address width
- ROM_DEPTH, 1001, number of writable ROM words (addresses 0..ROM_DEPTH-1)
- TIMEOUT_CYCLES, 1000000, maximum idle gap between bytes inside a frame

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_byte  in  8  received UART byte
- i_rx_dv  in  1  one-cycle strobe, i_rx_byte valid
- i_halt  in  1  level; return to boot mode from RUN
- o_rom_cs  out  1  1 = this block owns the ROM bus (boot mode)
- o_rom_write  out  1  one-cycle ROM write strobe
- o_rom_addr  out  ADDR_W  ROM write address
- o_rom_data  out  16  ROM write data
- o_cpu_reset  out  1  CPU reset; 1 in every state except RUN
- o_mode  out  1  0 = boot, 1 = run
- o_error  out  1  1 while in ERROR
- o_words_loaded  out  ADDR_W  words written in the current or last frame

## Operation
- Frame format: 0xA5 sync, count high byte, count low byte, then count words (each sent high byte first, then low byte), then one checksum byte.
- The checksum byte is the XOR of all data bytes. Sync and count bytes are excluded.
- States: IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CSUM, RUN, ERROR.
- IDLE:
  - A byte equal to 0xA5 moves to CNT_HI.
  - Any other byte is ignored.
- CNT_HI and CNT_LO latch the 16-bit count. After CNT_LO:
  - count == 0 goes to CSUM.
  - count > ROM_DEPTH goes to ERROR.
  - Otherwise go to DATA_HI, clear the word index, and clear the XOR accumulator.
- DATA_HI latches the high byte.
- DATA_LO writes the word {hi, lo} to address = word index, then increments the index.
  - When index+1 == count, go to CSUM.
  - Otherwise go to DATA_HI.
  - Each data byte is folded into the XOR accumulator.
- CSUM:
  - A byte equal to the accumulator goes to RUN.
  - A mismatch goes to ERROR.
- RUN:
  - o_rom_cs = 0, o_cpu_reset = 0, o_mode = 1.
  - Received bytes are ignored.
  - i_halt = 1 goes to IDLE.
- ERROR:
  - CPU stays in reset.
  - A 0xA5 byte goes to CNT_HI and clears o_error. All other bytes are ignored.
- Timeout: in CNT_HI..CSUM, a gap counter counts cycles without i_rx_dv. When it reaches TIMEOUT_CYCLES-1, go to ERROR. The counter clears on every accepted byte and on every state entry.
- o_words_loaded equals the word index. It is cleared on CNT_LO exit and held in RUN and ERROR.
- Partial images are not rolled back. Words already written stay in ROM on ERROR.

## Timing
- Reset values: state IDLE, o_rom_cs 1, o_rom_write 0, o_rom_addr 0, o_rom_data 0, o_cpu_reset 1, o_mode 0, o_error 0, o_words_loaded 0.
- Reset mid-frame aborts immediately. Any pending write strobe is dropped.
- Write latency:
  - The DATA_LO byte is accepted at cycle N.
  - o_rom_write = 1 at cycle N+1 only, with o_rom_addr and o_rom_data stable during N+1.
  - o_rom_addr and o_rom_data hold their values until the next write.
- A checksum byte arriving at N+1 is still accepted. The write at N+1 completes regardless.
- RUN entry: the checksum byte is accepted at cycle N. At N+1: state RUN, o_cpu_reset 0, o_rom_cs 0, o_mode 1.
- Halt: i_halt sampled at cycle N in RUN. At N+1: o_cpu_reset 1, o_rom_cs 1, o_mode 0.
- If i_halt and i_rx_dv are both high in RUN, halt wins and the byte is dropped. 0xA5 received at the cycle of RUN→IDLE is not a sync.
- If timeout expiry and i_rx_dv coincide, the byte is accepted and the counter clears.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package hack_pkg holds:
  - the state enum hack_boot_state_t;
  - the constant HACK_SYNC_BYTE = 8'hA5;
  - the constant HACK_ROM_DEPTH = 1001.
- One sub-module, hack_gap_timer:
  - parameter TIMEOUT_CYCLES;
  - inputs clear and enable;
  - output expired.
  - Counter width is $clog2(TIMEOUT_CYCLES).

## Test plan
- Reset → o_cpu_reset 1, o_rom_cs 1, o_mode 0. Frame A5 00 02 12 34 AB CD with csum 0x12^0x34^0xAB^0xCD = 0x40 → writes 0x1234@0 and 0xABCD@1, each a one-cycle strobe. RUN the cycle after the csum byte, o_words_loaded 2.
- Same frame with csum 0x41 → ERROR, o_error 1, o_cpu_reset 1. Then send a full valid frame → RUN, o_error 0.
- Frame A5 03 EA (count 1002 > 1001) → ERROR, no write strobe.
- Frame A5 00 00 00 → RUN with zero writes. Garbage bytes 0x11 0x22 in IDLE → ignored, state stays IDLE.
- TIMEOUT_CYCLES = 16, A5 00 01 12 then silence → ERROR exactly 16 cycles after the last byte. Assert i_reset mid-frame → IDLE next cycle, no strobe.
- In RUN, i_halt and i_rx_dv (0xA5) together → IDLE, o_cpu_reset 1 next cycle, byte dropped. The following A5 frame loads normally.
